ec_point_sub: RTL and testbench

//   Elliptic-curve point subtraction P = R - Q over GF(p), curve y^2 = x^3 + a*x + b.

---
 rtl/ec_point_sub.sv | 175 +++++++++++++++++
 tb/tb_ec_point_sub.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ec_point_sub.sv
// Elliptic-curve point subtraction P = R - Q over GF(p), computed as R + (-Q).
// A sequential Fermat inverter (den^(p-2), square-and-multiply) supplies the slope denominator inverse.
module ec_point_sub #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_Rx,
    input  logic [W-1:0] in_Ry,
    input  logic [W-1:0] in_Qx,
    input  logic [W-1:0] in_Qy,
    input  logic [W-1:0] in_prime,
    input  logic [W-1:0] in_a,
    output logic         out_valid,
    output logic [W-1:0] out_Px,
    output logic [W-1:0] out_Py,
    output logic         out_inf
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int PW = 2 * W + 2;
    localparam int SW = W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_INV,
        S_SLOPE,
        S_XCALC,
        S_YCALC
    } state_t;

    state_t r_state, w_state_next;

    logic [W-1:0]  r_rx, r_ry, r_qx, r_nqy, r_p, r_a;
    logic [W-1:0]  r_num, r_den, r_acc, r_e, r_s, r_px;
    logic [CW-1:0] r_cnt;
    logic          r_inf;
    logic          r_out_valid, r_out_inf;
    logic [W-1:0]  r_out_px, r_out_py;

    function automatic logic [W-1:0] f_mulmod(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic [W-1:0] m);
        logic [PW-1:0] prod;
        prod = PW'(x) * PW'(y);
        return W'(prod % PW'(m));
    endfunction

    function automatic logic [W-1:0] f_red(input logic [SW-1:0] v, input logic [W-1:0] m);
        return W'(v % SW'(m));
    endfunction

    // Negated subtrahend y: (p - Qy) mod p, so Qy = 0 maps to 0 rather than p.
    logic [W-1:0] w_nqy;
    assign w_nqy = (in_Qy == '0) ? '0 : in_prime - in_Qy;

    logic [W-1:0] w_rx_sq, w_dbl_num, w_dbl_den, w_gen_num, w_gen_den;
    assign w_rx_sq   = f_mulmod(r_rx, r_rx, r_p);
    assign w_dbl_num = f_red(SW'(3) * SW'(w_rx_sq) + SW'(r_a), r_p);
    assign w_dbl_den = f_red(SW'(r_ry) << 1, r_p);
    assign w_gen_num = f_red(SW'(r_nqy) + SW'(r_p) - SW'(r_ry), r_p);
    assign w_gen_den = f_red(SW'(r_qx) + SW'(r_p) - SW'(r_rx), r_p);

    logic [W-1:0] w_acc_sq, w_mult, w_acc_next, w_s;
    assign w_acc_sq   = f_mulmod(r_acc, r_acc, r_p);
    assign w_mult     = r_e[r_cnt] ? r_den : W'(1);
    assign w_acc_next = f_mulmod(w_acc_sq, w_mult, r_p);
    assign w_s        = f_mulmod(r_num, r_acc, r_p);

    logic [W-1:0]  w_s_sq, w_px, w_ys, w_py;
    logic [SW-1:0] w_dx;
    assign w_s_sq = f_mulmod(r_s, r_s, r_p);
    assign w_px   = f_red(SW'(w_s_sq) + (SW'(r_p) << 1) - SW'(r_rx) - SW'(r_qx), r_p);
    assign w_dx   = SW'(r_rx) + SW'(r_p) - SW'(r_px);
    assign w_ys   = W'((PW'(r_s) * PW'(w_dx)) % PW'(r_p));
    assign w_py   = f_red(SW'(w_ys) + SW'(r_p) - SW'(r_ry), r_p);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = S_PREP;
            S_PREP:  w_state_next = S_INV;
            S_INV:   if (r_cnt == '0) w_state_next = S_SLOPE;
            S_SLOPE: w_state_next = S_XCALC;
            S_XCALC: w_state_next = S_YCALC;
            S_YCALC: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx        <= '0;
            r_ry        <= '0;
            r_qx        <= '0;
            r_nqy       <= '0;
            r_p         <= '0;
            r_a         <= '0;
            r_num       <= '0;
            r_den       <= '0;
            r_acc       <= '0;
            r_e         <= '0;
            r_s         <= '0;
            r_px        <= '0;
            r_cnt       <= '0;
            r_inf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_inf   <= 1'b0;
            r_out_px    <= '0;
            r_out_py    <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_inf   <= 1'b0;
            r_out_px    <= '0;
            r_out_py    <= '0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_rx  <= in_Rx;
                        r_ry  <= in_Ry;
                        r_qx  <= in_Qx;
                        r_nqy <= w_nqy;
                        r_p   <= in_prime;
                        r_a   <= in_a;
                    end
                end
                S_PREP: begin
                    if (r_rx != r_qx) begin
                        r_num <= w_gen_num;
                        r_den <= w_gen_den;
                        r_inf <= 1'b0;
                    end else if (r_ry == r_nqy) begin
                        r_num <= w_dbl_num;
                        r_den <= w_dbl_den;
                        r_inf <= (w_dbl_den == '0);
                    end else begin
                        r_num <= '0;
                        r_den <= '0;
                        r_inf <= 1'b1;
                    end
                    r_acc <= W'(1);
                    r_cnt <= CW'(W - 1);
                    r_e   <= r_p - W'(2);
                end
                S_INV: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - CW'(1);
                end
                S_SLOPE: r_s  <= w_s;
                S_XCALC: r_px <= w_px;
                S_YCALC: begin
                    r_out_valid <= 1'b1;
                    r_out_inf   <= r_inf;
                    r_out_px    <= r_inf ? '0 : r_px;
                    r_out_py    <= r_inf ? '0 : w_py;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_inf   = r_out_inf;
    assign out_Px    = r_out_px;
    assign out_Py    = r_out_py;

endmodule

// File: tb/tb_ec_point_sub.sv
// Bench for ec_point_sub: directed curve scenarios plus random operands against an
// integer affine-arithmetic reference that uses a brute-force modular inverse.
module tb_ec_point_sub;

    localparam int W   = 6;
    localparam int LAT = W + 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_Rx, in_Ry, in_Qx, in_Qy, in_prime, in_a;
    logic         out_valid;
    logic [W-1:0] out_Px, out_Py;
    logic         out_inf;

    ec_point_sub #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_Rx    (in_Rx),
        .in_Ry    (in_Ry),
        .in_Qx    (in_Qx),
        .in_Qy    (in_Qy),
        .in_prime (in_prime),
        .in_a     (in_a),
        .out_valid(out_valid),
        .out_Px   (out_Px),
        .out_Py   (out_Py),
        .out_inf  (out_inf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        int px;
        int py;
        int inf;
    } res_t;

    res_t mon_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Record every result pulse; outside a pulse the outputs must read zero.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid === 1'b1) mon_q.push_back('{cyc, int'(out_Px), int'(out_Py), int'(out_inf)});
            else check("idle_zero", {19'd0, out_valid, out_Px, out_Py, out_inf}, 32'd0);
        end
    end

    function automatic int pmod(input int v, input int p);
        return ((v % p) + p) % p;
    endfunction

    function automatic int inv_mod(input int d, input int p);
        for (int x = 1; x < p; x++) if ((d * x) % p == 1) return x;
        return 0;
    endfunction

    task automatic ref_sub(input int rx, input int ry, input int qx, input int qy, input int p,
                           input int a, output int px, output int py, output int inf);
        int nqy, lam;
        nqy = pmod(-qy, p);
        inf = 0;
        lam = 0;
        if (rx != qx) lam = pmod((nqy - ry) * inv_mod(pmod(qx - rx, p), p), p);
        else if (ry == nqy && pmod(2 * ry, p) != 0)
            lam = pmod((3 * rx * rx + a) * inv_mod(pmod(2 * ry, p), p), p);
        else inf = 1;
        if (inf) begin
            px = 0;
            py = 0;
        end else begin
            px = pmod(lam * lam - rx - qx, p);
            py = pmod(lam * (rx - px) - ry, p);
        end
    endtask

    task automatic issue(input int rx, input int ry, input int qx, input int qy, input int p,
                         input int a, output int k);
        @(negedge clk);
        in_Rx    = W'(rx);
        in_Ry    = W'(ry);
        in_Qx    = W'(qx);
        in_Qy    = W'(qy);
        in_prime = W'(p);
        in_a     = W'(a);
        in_valid = 1'b1;
        k        = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_res(input string tag, input int k, input int px, input int py, input int inf);
        int   budget;
        res_t r;
        budget = 0;
        while (mon_q.size() == 0 && budget < 4 * LAT) begin
            @(posedge clk);
            budget++;
        end
        if (mon_q.size() == 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            r = mon_q.pop_front();
            check({tag, "_lat"}, r.c - k, LAT);
            check({tag, "_px"}, r.px, px);
            check({tag, "_py"}, r.py, py);
            check({tag, "_inf"}, r.inf, inf);
        end
    endtask

    task automatic run_ref(input string tag, input int rx, input int ry, input int qx, input int qy,
                           input int p, input int a);
        int k, px, py, inf;
        ref_sub(rx, ry, qx, qy, p, a, px, py, inf);
        issue(rx, ry, qx, qy, p, a, k);
        expect_res(tag, k, px, py, inf);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int primes[17] = '{3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61};

    initial begin
        int k, k2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_Rx    = '0;
        in_Ry    = '0;
        in_Qx    = '0;
        in_Qy    = '0;
        in_prime = '0;
        in_a     = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_px", 32'(out_Px), 32'd0);
        check("rst_py", 32'(out_Py), 32'd0);
        check("rst_inf", 32'(out_inf), 32'd0);
        rst_n = 1'b1;

        // Curve p=17, a=2: G=(5,1), 2G=(6,3), 3G=(10,6); expectations are hand-derived.
        issue(6, 3, 5, 1, 17, 2, k);
        expect_res("s1", k, 5, 1, 0);
        issue(10, 6, 5, 1, 17, 2, k);
        expect_res("s2a", k, 6, 3, 0);
        issue(10, 6, 6, 3, 17, 2, k);
        expect_res("s2b", k, 5, 1, 0);
        issue(5, 1, 5, 16, 17, 2, k);
        expect_res("s3_dbl", k, 6, 3, 0);
        issue(5, 1, 5, 1, 17, 2, k);
        expect_res("s4_inf", k, 0, 0, 1);

        // A second pulse while busy is dropped.
        issue(6, 3, 5, 1, 17, 2, k);
        repeat (2) @(negedge clk);
        issue(10, 6, 5, 1, 17, 2, k2);
        expect_res("s5_busy", k, 5, 1, 0);
        repeat (3 * LAT) @(posedge clk);
        check("s5_no_extra", mon_q.size(), 0);

        // A pulse during the out_valid cycle is accepted.
        issue(10, 6, 6, 3, 17, 2, k);
        repeat (LAT - 1) @(negedge clk);
        issue(10, 6, 5, 1, 17, 2, k2);
        expect_res("s5_b2b_first", k, 5, 1, 0);
        expect_res("s5_b2b_second", k2, 6, 3, 0);

        // Reset while the inverter is running aborts the operation.
        issue(6, 3, 5, 1, 17, 2, k);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("s6_rst_valid", 32'(out_valid), 32'd0);
        check("s6_rst_out", {out_Px, out_Py, out_inf}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * LAT) @(posedge clk);
        check("s6_no_stale", mon_q.size(), 0);
        issue(6, 3, 5, 1, 17, 2, k);
        expect_res("s6_after", k, 5, 1, 0);

        for (int i = 0; i < 80; i++) begin
            int p, a, rx, ry, qx, qy, mode;
            p    = primes[$urandom_range(16, 0)];
            a    = $urandom_range(p - 1, 0);
            rx   = $urandom_range(p - 1, 0);
            ry   = $urandom_range(p - 1, 0);
            mode = $urandom_range(3, 0);
            if (mode == 1) begin
                qx = rx;
                qy = pmod(-ry, p);
            end else if (mode == 2) begin
                qx = rx;
                qy = ry;
            end else begin
                qx = $urandom_range(p - 1, 0);
                qy = $urandom_range(p - 1, 0);
            end
            run_ref("rand", rx, ry, qx, qy, p, a);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
